// File: rtl/in_spk_loader_pkg.sv
// Shared definitions for the input-spike SRAM loader and its consumers.
package in_spk_loader_pkg;

  localparam int IN_SPK_CHUNKS = 8;
  localparam int IN_SPK_DEPTH  = 512;
  localparam int IN_SPK_CNT_W  = 10;  // word counter / frame length width (0..512)

  // Loader FSM state, exported so the control unit can observe it for debug.
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FULL  = 2'd2
  } spk_state_e;

  // Frame length of 0 or anything beyond the SRAM depth means a full SRAM.
  function automatic logic [IN_SPK_CNT_W-1:0] decode_frame_words(input logic [IN_SPK_CNT_W-1:0] fw);
    logic [IN_SPK_CNT_W-1:0] len;
    len = fw;
    if (fw == '0 || fw > IN_SPK_CNT_W'(IN_SPK_DEPTH))
      len = IN_SPK_CNT_W'(IN_SPK_DEPTH);
    return len;
  endfunction

endpackage

// File: rtl/spk_chunk_packer.sv
// Packs stream chunks into one SRAM word. The completed word is presented
// combinationally in the accepting cycle so the caller can register it.
// Because the pack register is cleared after every emitted word, slots above
// the current index are already zero, which gives the early-last zero pad.
module spk_chunk_packer
  import in_spk_loader_pkg::*;
#(
  parameter int CHUNK_W = 16,
  parameter int WORD_W  = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               accept,
  input  logic               pad,
  input  logic [CHUNK_W-1:0] data,
  output logic [2:0]         k,
  output logic [WORD_W-1:0]  word,
  output logic               word_valid
);

  logic [WORD_W-1:0] pack_reg;
  logic [2:0]        k_reg;

  // Merge the incoming chunk into its slot; other slots keep the packed value.
  for (genvar gi = 0; gi < IN_SPK_CHUNKS; gi++) begin : g_slot
    assign word[gi*CHUNK_W +: CHUNK_W] = (accept && k_reg == 3'(gi)) ? data
                                                                      : pack_reg[gi*CHUNK_W +: CHUNK_W];
  end

  assign word_valid = accept && (k_reg == 3'd7 || pad);
  assign k          = k_reg;

  // Pack register and chunk index: advance on accept, restart after each word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_reg <= '0;
      k_reg    <= '0;
    end else if (clear) begin
      pack_reg <= '0;
      k_reg    <= '0;
    end else if (accept) begin
      if (word_valid) begin
        pack_reg <= '0;
        k_reg    <= '0;
      end else begin
        pack_reg <= word;
        k_reg    <= k_reg + 3'd1;
      end
    end
  end

endmodule

// File: rtl/in_spk_loader.sv
// Input-spike SRAM loader: accepts a chunk stream, packs eight chunks per
// word, writes words from address 0 and holds a complete frame until the
// control unit reports it consumed.
module in_spk_loader
  import in_spk_loader_pkg::*;
#(
  parameter int CHUNK_W = 16,
  parameter int WORD_W  = 128,
  parameter int ADDR_W  = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHUNK_W-1:0]      s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  input  logic [IN_SPK_CNT_W-1:0] frame_words,
  input  logic                    frame_consumed,
  output logic [WORD_W-1:0]       in_spk_write_sram,
  output logic [ADDR_W-1:0]       in_spk_write_sram_addr,
  output logic                    in_spk_write_sram_we,
  output logic                    frame_ready,
  output logic [7:0]              frames_loaded,
  output logic                    err_framing
);

  spk_state_e              state_reg, state_next;
  logic                    pending_reg;      // final word is being written this cycle
  logic [IN_SPK_CNT_W-1:0] word_cnt_reg;
  logic [IN_SPK_CNT_W-1:0] len_reg;
  logic [7:0]              frames_reg;
  logic                    err_reg;
  logic                    we_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [WORD_W-1:0]       data_reg;

  logic                    accept;
  logic [2:0]              k;
  logic [WORD_W-1:0]       packed_word;
  logic                    word_valid;
  logic                    first_chunk;
  logic [IN_SPK_CNT_W-1:0] len_eff;
  logic                    last_word;
  logic                    early_last;
  logic                    flush_issue;
  logic                    final_issue;
  logic                    consume;

  assign accept      = s_valid && s_ready;
  assign first_chunk = (k == 3'd0) && (word_cnt_reg == '0);
  // The length is sampled on the first chunk, so use the live value that cycle.
  assign len_eff     = first_chunk ? decode_frame_words(frame_words) : len_reg;
  assign last_word   = (word_cnt_reg == len_eff - IN_SPK_CNT_W'(1));
  assign early_last  = accept && s_last && !((k == 3'd7) && last_word);
  assign flush_issue = (state_reg == ST_FLUSH) && !pending_reg;
  assign final_issue = (word_valid && last_word) ||
                       (flush_issue && word_cnt_reg == len_reg - IN_SPK_CNT_W'(1));
  assign consume     = (state_reg == ST_FULL) && frame_consumed;

  spk_chunk_packer #(
    .CHUNK_W (CHUNK_W),
    .WORD_W  (WORD_W)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (consume),
    .accept     (accept),
    .pad        (early_last),
    .data       (s_data),
    .k          (k),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_FILL;
    else       state_reg <= state_next;
  end

  // FSM next state: the final-word write cycle always leads to FULL.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FILL: begin
        if (pending_reg)                   state_next = ST_FULL;
        else if (early_last && !last_word) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pending_reg) state_next = ST_FULL;
      end
      ST_FULL: begin
        if (frame_consumed) state_next = ST_FILL;
      end
      default: state_next = ST_FILL;
    endcase
  end

  // FSM outputs: ready only while filling with no final write in flight.
  always_comb begin
    s_ready     = (state_reg == ST_FILL) && !pending_reg;
    frame_ready = (state_reg == ST_FULL);
  end

  // Word counter, latched frame length, final-write flag and frame count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt_reg <= '0;
      len_reg      <= '0;
      pending_reg  <= 1'b0;
      frames_reg   <= '0;
    end else begin
      pending_reg <= final_issue;
      if (consume)
        word_cnt_reg <= '0;
      else if (word_valid || flush_issue)
        word_cnt_reg <= word_cnt_reg + IN_SPK_CNT_W'(1);
      if (accept && first_chunk)
        len_reg <= decode_frame_words(frame_words);
      if (pending_reg)
        frames_reg <= frames_reg + 8'd1;
    end
  end

  // Sticky framing error: early s_last, or final chunk without s_last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_reg <= 1'b0;
    else if (early_last || (word_valid && last_word && (k == 3'd7) && !s_last))
      err_reg <= 1'b1;
  end

  // Registered SRAM write port: packed words in FILL, zero words in FLUSH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg   <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else if (word_valid) begin
      we_reg   <= 1'b1;
      addr_reg <= word_cnt_reg[ADDR_W-1:0];
      data_reg <= packed_word;
    end else if (flush_issue) begin
      we_reg   <= 1'b1;
      addr_reg <= word_cnt_reg[ADDR_W-1:0];
      data_reg <= '0;
    end else begin
      we_reg   <= 1'b0;
    end
  end

  assign in_spk_write_sram      = data_reg;
  assign in_spk_write_sram_addr = addr_reg;
  assign in_spk_write_sram_we   = we_reg;
  assign frames_loaded          = frames_reg;
  assign err_framing            = err_reg;

endmodule

// File: tb/tb_in_spk_loader.sv
// Randomized scoreboard bench for in_spk_loader.
module tb_in_spk_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [9:0]   frame_words = '0;
  logic         frame_consumed = 1'b0;
  logic [127:0] in_spk_write_sram;
  logic [8:0]   in_spk_write_sram_addr;
  logic         in_spk_write_sram_we;
  logic         frame_ready;
  logic [7:0]   frames_loaded;
  logic         err_framing;

  in_spk_loader dut (
    .clk                    (clk),
    .reset                  (reset),
    .s_data                 (s_data),
    .s_valid                (s_valid),
    .s_last                 (s_last),
    .s_ready                (s_ready),
    .frame_words            (frame_words),
    .frame_consumed         (frame_consumed),
    .in_spk_write_sram      (in_spk_write_sram),
    .in_spk_write_sram_addr (in_spk_write_sram_addr),
    .in_spk_write_sram_we   (in_spk_write_sram_we),
    .frame_ready            (frame_ready),
    .frames_loaded          (frames_loaded),
    .err_framing            (err_framing)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]   addr;
    logic [127:0] data;
    logic         fin;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] chunk_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  frames_exp = '0;
  bit          err_exp = 1'b0;
  int          stalls = 0;
  bit          chk_ready_next = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_len(input int fw);
    return (fw == 0 || fw > 512) ? 512 : fw;
  endfunction

  // Reference model: chunk i of the frame goes to word i/8, slot i%8; words
  // not reached before s_last are all zero; every word up to N-1 is written.
  task automatic build_frame(input int fw, input int last_idx, input bit seq, output int nsend);
    int n;
    logic [127:0] w;
    n = eff_len(fw);
    chunk_q.delete();
    nsend = (last_idx >= 0) ? last_idx + 1 : n * 8;
    for (int i = 0; i < nsend; i++)
      chunk_q.push_back(seq ? 16'(i + 1) : 16'($urandom));
    for (int wi = 0; wi < n; wi++) begin
      w = '0;
      for (int c = 0; c < 8; c++)
        if (wi * 8 + c < nsend) w[c*16 +: 16] = chunk_q[wi*8 + c];
      exp_q.push_back('{addr: 9'(wi), data: w, fin: (wi == n - 1)});
    end
    if (last_idx != n * 8 - 1) err_exp = 1'b1;
    frames_exp++;
  endtask

  // Drive chunks; leaves s_valid set from the last driven chunk.
  task automatic send_frame(input int fw, input int nsend, input int last_idx,
                            input bit gaps, input bit pulse_fill);
    int  i;
    int  cyc;
    bit  pulsed;
    i = 0; cyc = 0; pulsed = 1'b0; stalls = 0;
    frame_words = 10'(fw);
    while (i < nsend && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      frame_consumed = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0; s_last = 1'b0; s_data = 16'($urandom);
      end else begin
        s_valid = 1'b1; s_data = chunk_q[i]; s_last = (i == last_idx);
      end
      if (pulse_fill && !pulsed && i == 3) begin
        frame_consumed = 1'b1; pulsed = 1'b1;
      end
      if (s_valid) begin
        if (s_ready) i++;
        else stalls++;
      end
    end
    if (i < nsend) check("send_timeout", 128'(i), 128'(nsend));
  endtask

  // Wait for frame_ready, check status, then release the frame.
  task automatic finish_frame(input bit hold_valid);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      frame_consumed = 1'b0;
      if (!hold_valid) begin s_valid = 1'b0; s_last = 1'b0; end
      else check("s_ready_hold", 128'(s_ready), 128'(0));
      cyc++;
    end while (!frame_ready && cyc < 10000);
    check("frame_ready", 128'(frame_ready), 128'(1));
    check("frames_loaded", 128'(frames_loaded), 128'(frames_exp));
    check("err_framing", 128'(err_framing), 128'(err_exp));
    check("s_ready_full", 128'(s_ready), 128'(0));
    if (hold_valid) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        check("s_ready_full_hold", 128'(s_ready), 128'(0));
      end
      s_valid = 1'b0; s_last = 1'b0;
    end
    @(negedge clk);
    frame_consumed = 1'b1;
    @(negedge clk);
    frame_consumed = 1'b0;
    check("frame_ready_fall", 128'(frame_ready), 128'(0));
    check("s_ready_rise", 128'(s_ready), 128'(1));
    $display("frame done: frames_loaded=%0d err=%0d", frames_loaded, err_framing);
  endtask

  // Monitor: pop one expected write per strobe and check frame_ready timing.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk_ready_next = 1'b0;
    end else begin
      if (chk_ready_next) begin
        check("frame_ready_rise", 128'(frame_ready), 128'(1));
        chk_ready_next = 1'b0;
      end
      if (in_spk_write_sram_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 128'(in_spk_write_sram_addr), 128'h1ff_dead);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 128'(in_spk_write_sram_addr), 128'(e.addr));
          check("wr_data", in_spk_write_sram, e.data);
          if (e.fin) begin
            check("frame_ready_early", 128'(frame_ready), 128'(0));
            chk_ready_next = 1'b1;
          end
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 128'(s_ready), 128'(1));
    check({tag, "_we"}, 128'(in_spk_write_sram_we), 128'(0));
    check({tag, "_addr"}, 128'(in_spk_write_sram_addr), 128'(0));
    check({tag, "_data"}, in_spk_write_sram, 128'(0));
    check({tag, "_frame_ready"}, 128'(frame_ready), 128'(0));
    check({tag, "_frames_loaded"}, 128'(frames_loaded), 128'(0));
    check({tag, "_err"}, 128'(err_framing), 128'(0));
  endtask

  initial begin
    int nsend;
    int fw;
    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("rst");

    // Single-word frame with sequential data
    build_frame(1, 7, 1'b1, nsend);
    send_frame(1, nsend, 7, 1'b0, 1'b0);
    check("single_stalls", 128'(stalls), 128'(0));
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("single_we_latency", 128'(in_spk_write_sram_we), 128'(1));
    check("single_addr", 128'(in_spk_write_sram_addr), 128'(0));
    check("single_data", in_spk_write_sram, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    finish_frame(1'b0);

    // Full 512-word frame, s_valid held high
    build_frame(512, 4095, 1'b0, nsend);
    send_frame(512, nsend, 4095, 1'b0, 1'b0);
    check("full_stalls", 128'(stalls), 128'(0));
    finish_frame(1'b0);

    // Early s_last on chunk 2 of word 1
    build_frame(4, 10, 1'b0, nsend);
    send_frame(4, nsend, 10, 1'b0, 1'b0);
    finish_frame(1'b0);

    // frame_words=0 decodes to 512, no s_last at all, s_valid held in FULL
    build_frame(0, -1, 1'b0, nsend);
    send_frame(0, nsend, -1, 1'b0, 1'b0);
    finish_frame(1'b1);
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    // Reset mid-frame after 13 chunks; only word 0 gets written
    build_frame(4, -1, 1'b0, nsend);
    exp_q.delete();
    begin
      logic [127:0] w0;
      for (int c = 0; c < 8; c++) w0[c*16 +: 16] = chunk_q[c];
      exp_q.push_back('{addr: 9'd0, data: w0, fin: 1'b0});
    end
    send_frame(4, 13, -1, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_values("async_rst");
    check("abort_queue", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    s_valid = 1'b0;
    frames_exp = '0;
    err_exp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 256 random frames with gaps; one stray frame_consumed pulse in FILL
    for (int f = 0; f < 256; f++) begin
      fw = $urandom_range(1, 3);
      build_frame(fw, fw * 8 - 1, 1'b0, nsend);
      send_frame(fw, nsend, fw * 8 - 1, 1'b1, (f == 5));
      finish_frame(1'b0);
    end
    check("frames_wrap", 128'(frames_loaded), 128'(0));
    check("final_queue", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
